// File: rtl/debug_display_pkg.sv
// Shared constants and state encoding for the debug display scanner.
// OFF/ERR words are 32-bit and zero-extended by users that need wider buses.
package debug_display_pkg;

  localparam logic [31:0] OFF_PATTERN = 32'h0000_0FF0;
  localparam logic [31:0] ERR_PATTERN = 32'h0000_DEDE;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level debouncer and
// a one-cycle pulse on each accepted rising level change.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic button,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      pulse_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= button;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg    <= '0;
        stable_reg <= sync2_reg;
        pulse_reg  <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/debug_display_scanner.sv
// Selects one of NUM_CH debug channels onto a registered hex display bus,
// by switch, by timed auto-scan, or frozen with single-step from a button.
module debug_display_scanner
  import debug_display_pkg::*;
#(
  parameter int NUM_CH       = 19,
  parameter int DATA_W       = 32,
  parameter int SEL_W        = 5,
  parameter int DWELL_CYC    = 50_000_000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] Channel_Data,
  input  logic [SEL_W-1:0]         Display_Select,
  input  logic                     Display_Enable,
  input  logic                     Scan_Mode,
  input  logic                     Freeze,
  input  logic                     Step_Button,
  output logic [DATA_W-1:0]        HexDisplay32Bits,
  output logic [SEL_W-1:0]         Active_Channel,
  output logic                     Display_Valid
);

  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] OFF_WORD   = DATA_W'(OFF_PATTERN);
  localparam logic [DATA_W-1:0] ERR_WORD   = DATA_W'(ERR_PATTERN);

  state_t state_reg, state_next;

  logic [SEL_W-1:0]  idx_reg, idx_next;
  logic [DW_W-1:0]   dwell_reg, dwell_next;
  logic [DATA_W-1:0] word_reg, word_next;
  logic [SEL_W-1:0]  active_reg, active_next;
  logic              valid_reg, valid_next;
  logic              step_pulse;
  logic              sel_in_range;

  logic [DATA_W-1:0] ch_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_arr[gi] = Channel_Data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  button_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_step_debounce (
    .clk   (Clock),
    .srst  (Reset),
    .button(Step_Button),
    .pulse (step_pulse)
  );

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    return (i == LAST_CH) ? '0 : i + 1'b1;
  endfunction

  assign sel_in_range = ({1'b0, Display_Select} < (SEL_W + 1)'(NUM_CH));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_OFF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = ST_MANUAL;
    if (!Display_Enable) begin
      state_next = ST_OFF;
    end else if (Freeze) begin
      state_next = ST_HOLD;
    end else if (Scan_Mode) begin
      state_next = ST_SCAN;
    end
  end

  // Outputs are computed for the state being entered, so any input change
  // reaches the display after exactly one edge.
  always_comb begin
    idx_next    = idx_reg;
    dwell_next  = dwell_reg;
    word_next   = word_reg;
    active_next = active_reg;
    valid_next  = valid_reg;
    case (state_next)
      ST_OFF: begin
        word_next  = OFF_WORD;
        valid_next = 1'b0;
      end
      ST_MANUAL: begin
        dwell_next  = '0;
        active_next = Display_Select;
        if (sel_in_range) begin
          idx_next   = Display_Select;
          word_next  = ch_arr[Display_Select];
          valid_next = 1'b1;
        end else begin
          word_next  = ERR_WORD;
          valid_next = 1'b0;
        end
      end
      ST_SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          idx_next   = wrap_inc(idx_reg);
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
        word_next   = ch_arr[idx_next];
        active_next = idx_next;
        valid_next  = 1'b1;
      end
      ST_HOLD: begin
        // A step only counts while already frozen; a pulse coinciding with
        // Freeze edges is dropped.
        if (step_pulse && (state_reg == ST_HOLD)) begin
          idx_next    = wrap_inc(idx_reg);
          word_next   = ch_arr[idx_next];
          active_next = idx_next;
          valid_next  = 1'b1;
        end
      end
      default: begin
        word_next  = OFF_WORD;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_reg    <= '0;
      dwell_reg  <= '0;
      word_reg   <= OFF_WORD;
      active_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      idx_reg    <= idx_next;
      dwell_reg  <= dwell_next;
      word_reg   <= word_next;
      active_reg <= active_next;
      valid_reg  <= valid_next;
    end
  end

  assign HexDisplay32Bits = word_reg;
  assign Active_Channel   = active_reg;
  assign Display_Valid    = valid_reg;

endmodule

// File: tb/tb_debug_display_scanner.sv
// Directed bench for debug_display_scanner: manual, scan, freeze/step,
// freeze at terminal count and mid-scan reset.
module tb_debug_display_scanner;

  localparam int NUM_CH = 19;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;

  logic                     Clock = 1'b0;
  logic                     Reset;
  logic [NUM_CH*DATA_W-1:0] Channel_Data;
  logic [SEL_W-1:0]         Display_Select;
  logic                     Display_Enable;
  logic                     Scan_Mode;
  logic                     Freeze;
  logic                     Step_Button;
  logic [DATA_W-1:0]        HexDisplay32Bits;
  logic [SEL_W-1:0]         Active_Channel;
  logic                     Display_Valid;

  int checks = 0;
  int errors = 0;

  debug_display_scanner #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .SEL_W       (SEL_W),
    .DWELL_CYC   (4),
    .DEBOUNCE_CYC(3)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Channel_Data    (Channel_Data),
    .Display_Select  (Display_Select),
    .Display_Enable  (Display_Enable),
    .Scan_Mode       (Scan_Mode),
    .Freeze          (Freeze),
    .Step_Button     (Step_Button),
    .HexDisplay32Bits(HexDisplay32Bits),
    .Active_Channel  (Active_Channel),
    .Display_Valid   (Display_Valid)
  );

  always #5 Clock = ~Clock;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-12s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [31:0] w, input int ch, input logic v);
    check({tag, ".word"}, HexDisplay32Bits, w);
    check({tag, ".chan"}, 32'(Active_Channel), 32'(ch));
    check({tag, ".valid"}, 32'(Display_Valid), 32'(v));
  endtask

  task automatic wait_word_change(input logic [31:0] old_word, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (HexDisplay32Bits !== old_word) break;
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) Channel_Data[k*DATA_W +: DATA_W] = 32'hC0DE_0000 + 32'(k);
    Reset          = 1'b1;
    Display_Select = '0;
    Display_Enable = 1'b0;
    Scan_Mode      = 1'b0;
    Freeze         = 1'b0;
    Step_Button    = 1'b0;

    // Reset and OFF
    ticks(2);
    Reset = 1'b0;
    tick();
    check_out("reset_off", 32'h0000_0FF0, 0, 1'b0);

    // Manual select
    Display_Enable = 1'b1;
    Display_Select = 5'd7;
    tick();
    check_out("manual7", 32'hC0DE_0007, 7, 1'b1);
    Display_Select = 5'd20;
    tick();
    check_out("manual20", 32'h0000_DEDE, 20, 1'b0);
    Display_Select = 5'd17;
    tick();
    check_out("manual17", 32'hC0DE_0011, 17, 1'b1);

    // Auto-scan from 17: one step every 4 edges, wrapping 18 -> 0
    Scan_Mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int exp_idx;
      tick();
      exp_idx = (17 + k / 4) % NUM_CH;
      check($sformatf("scan%0d.word", k), HexDisplay32Bits, 32'hC0DE_0000 + 32'(exp_idx));
      check($sformatf("scan%0d.chan", k), 32'(Active_Channel), 32'(exp_idx));
    end

    // Freeze at index 3 while channel 3 changes underneath
    Freeze = 1'b1;
    Channel_Data[3*DATA_W +: DATA_W] = 32'h1234_5678;
    tick();
    check_out("hold3a", 32'hC0DE_0003, 3, 1'b1);
    ticks(5);
    check_out("hold3b", 32'hC0DE_0003, 3, 1'b1);

    // First clean step press
    Step_Button = 1'b1;
    wait_word_change(32'hC0DE_0003, 20);
    check_out("step1", 32'hC0DE_0004, 4, 1'b1);
    ticks(6);
    check("step1_hold", HexDisplay32Bits, 32'hC0DE_0004);
    Step_Button = 1'b0;
    ticks(10);
    check("step1_rel", HexDisplay32Bits, 32'hC0DE_0004);

    // Second clean step press
    Step_Button = 1'b1;
    wait_word_change(32'hC0DE_0004, 20);
    check_out("step2", 32'hC0DE_0005, 5, 1'b1);
    ticks(4);
    Step_Button = 1'b0;
    ticks(10);

    // Two-cycle glitch must be rejected
    Step_Button = 1'b1;
    ticks(2);
    Step_Button = 1'b0;
    ticks(12);
    check_out("glitch", 32'hC0DE_0005, 5, 1'b1);

    // Freeze landing on the terminal count at index 5
    Freeze = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("pre_tc%0d", k), HexDisplay32Bits, 32'hC0DE_0005);
    end
    Freeze = 1'b1;
    tick();
    check("tc_frz_a", HexDisplay32Bits, 32'hC0DE_0005);
    tick();
    check("tc_frz_b", 32'(Active_Channel), 32'd5);
    Freeze = 1'b0;
    tick();
    check_out("tc_resume", 32'hC0DE_0006, 6, 1'b1);
    tick();
    check("tc_dwell", HexDisplay32Bits, 32'hC0DE_0006);

    // Scan on to index 9, then reset mid-scan
    ticks(11);
    check_out("scan9", 32'hC0DE_0009, 9, 1'b1);
    Reset = 1'b1;
    tick();
    check_out("rst_mid", 32'h0000_0FF0, 0, 1'b0);
    Display_Enable = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check_out("rst_off", 32'h0000_0FF0, 0, 1'b0);

    // Scan restarts from index 0
    Display_Enable = 1'b1;
    tick();
    check_out("restart0", 32'hC0DE_0000, 0, 1'b1);
    ticks(3);
    check_out("restart1", 32'hC0DE_0001, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
